// File: rtl/dense_fold_scheduler_pkg.sv
// Shared types and elaboration-time helpers for the folded dense-layer scheduler.
package dense_sched_pkg;

  localparam int MAX_PACK = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  function automatic int calc_ngroup(input int output_size, input int pack);
    return (output_size + pack - 1) / pack;
  endfunction

  // Issue-to-result latency: DSP stages, adder tree, then the bias/output register.
  function automatic int calc_pipe_lat(input int input_size, input int mult_lat);
    return mult_lat + $clog2(input_size) + 1;
  endfunction

  function automatic logic [MAX_PACK-1:0] calc_lane_mask(input int grp, input int pack,
                                                         input int output_size);
    logic [MAX_PACK-1:0] mask;
    mask = '0;
    for (int k = 0; k < MAX_PACK; k++) begin
      if ((k < pack) && ((grp * pack + k) < output_size)) begin
        mask[k] = 1'b1;
      end else begin
        mask[k] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/dense_fold_scheduler_if.sv
// Handshake, issue and result-write bus between the fold scheduler and its neighbours.
interface dense_fold_scheduler_if #(
  parameter int OUTPUT_SIZE = 5,
  parameter int PACK        = 3
);
  import dense_sched_pkg::*;

  localparam int NGROUP = calc_ngroup(OUTPUT_SIZE, PACK);
  localparam int GW     = $clog2(NGROUP) + 1;
  localparam int CW     = $clog2(OUTPUT_SIZE + PACK);

  logic          in_valid;
  logic          in_ready;
  logic          load_en;
  logic          issue_valid;
  logic [GW-1:0] grp_idx;
  logic [CW-1:0] col_base;
  logic [PACK-1:0] lane_mask;
  logic          wr_en;
  logic [GW-1:0] wr_idx;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, load_en, issue_valid, grp_idx, col_base, lane_mask,
           wr_en, wr_idx, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, load_en, issue_valid, grp_idx, col_base, lane_mask,
           wr_en, wr_idx, out_valid, busy
  );

endinterface

// File: rtl/dense_fold_scheduler_latency_tracker.sv
// Fixed-depth valid+tag delay line with synchronous clear, for any fixed-latency datapath.
module latency_tracker #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic             valid_r [DEPTH];
  logic [TAG_W-1:0] tag_r   [DEPTH];

  // Advance every stage each cycle; clear drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      tag_r[0]   <= in_valid ? in_tag : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        tag_r[i]   <= tag_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_tag   = tag_r[DEPTH-1];

endmodule

// File: rtl/dense_fold_scheduler.sv
// Sequencer for a folded dense layer: issues PACK-wide column groups, tracks them through
// the fixed datapath latency, strobes result writes and hands off the finished vector.
module dense_fold_scheduler #(
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 5,
  parameter int PACK        = 3,
  parameter int MULT_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  dense_fold_scheduler_if.master bus
);
  import dense_sched_pkg::*;

  localparam int NGROUP   = calc_ngroup(OUTPUT_SIZE, PACK);
  localparam int PIPE_LAT = calc_pipe_lat(INPUT_SIZE, MULT_LAT);
  localparam int GW       = $clog2(NGROUP) + 1;
  localparam int CW       = $clog2(OUTPUT_SIZE + PACK);
  localparam logic [GW-1:0] LAST_GRP = GW'(NGROUP - 1);

  sched_state_e        state_r, state_s;
  logic [GW-1:0]       grp_r, grp_s;
  logic                issue_s;
  logic                trk_valid_s;
  logic [GW-1:0]       trk_tag_s;
  logic [MAX_PACK-1:0] mask_full_s;

  // State and group counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grp_r   <= '0;
    end else begin
      state_r <= state_s;
      grp_r   <= grp_s;
    end
  end

  // Next-state and group-counter logic.
  always_comb begin
    state_s = state_r;
    grp_s   = grp_r;
    case (state_r)
      ST_IDLE: begin
        grp_s = '0;
        if (bus.in_valid) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (grp_r == LAST_GRP) begin
          state_s = ST_DRAIN;
          grp_s   = '0;
        end else begin
          state_s = ST_ISSUE;
          grp_s   = grp_r + GW'(1);
        end
      end
      ST_DRAIN: begin
        // Groups retire in issue order, so the last tag marks the whole vector done.
        if (trk_valid_s && (trk_tag_s == LAST_GRP)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grp_s   = '0;
      end
    endcase
  end

  assign issue_s = (state_r == ST_ISSUE);

  latency_tracker #(
    .DEPTH (PIPE_LAT),
    .TAG_W (GW)
  ) u_tracker (
    .clk       (clk),
    .clr       (reset),
    .in_valid  (issue_s),
    .in_tag    (grp_r),
    .out_valid (trk_valid_s),
    .out_tag   (trk_tag_s)
  );

  // Output decode from the registered state and group counter.
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.load_en     = 1'b0;
    bus.issue_valid = 1'b0;
    bus.grp_idx     = '0;
    bus.col_base    = '0;
    bus.lane_mask   = '0;
    bus.out_valid   = 1'b0;
    mask_full_s     = calc_lane_mask(int'(grp_r), PACK, OUTPUT_SIZE);
    case (state_r)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.load_en  = bus.in_valid;
      end
      ST_ISSUE: begin
        bus.issue_valid = 1'b1;
        bus.grp_idx     = grp_r;
        bus.col_base    = CW'(int'(grp_r) * PACK);
        bus.lane_mask   = mask_full_s[PACK-1:0];
      end
      ST_DRAIN: begin
        bus.in_ready = 1'b0;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

  assign bus.wr_en  = trk_valid_s;
  assign bus.wr_idx = trk_tag_s;
  assign bus.busy   = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dense_fold_scheduler.sv
// Bench for dense_fold_scheduler: timing table, directed corner sequences, and random
// traffic on two configurations compared against a cycle-offset reference model.
module tb_dense_fold_scheduler;

  localparam int A_IN = 32, A_OUT = 5, A_PACK = 3, A_ML = 2;
  localparam int A_NG = 2, A_PL = 8;
  localparam int B_IN = 7, B_OUT = 3, B_PACK = 3, B_ML = 2;
  localparam int B_NG = 1, B_PL = 6;

  typedef struct packed {
    int in_ready; int load_en; int issue_valid; int grp_idx; int col_base;
    int lane_mask; int wr_en; int wr_idx; int out_valid; int busy;
  } obs_t;

  typedef struct packed { int active; int t; } mstate_t;
  typedef struct packed { int iv; int orr; obs_t e; } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl [13];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dense_fold_scheduler_if #(.OUTPUT_SIZE(A_OUT), .PACK(A_PACK)) ifa ();
  dense_fold_scheduler_if #(.OUTPUT_SIZE(B_OUT), .PACK(B_PACK)) ifb ();

  dense_fold_scheduler #(.INPUT_SIZE(A_IN), .OUTPUT_SIZE(A_OUT), .PACK(A_PACK), .MULT_LAT(A_ML))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  dense_fold_scheduler #(.INPUT_SIZE(B_IN), .OUTPUT_SIZE(B_OUT), .PACK(B_PACK), .MULT_LAT(B_ML))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  function automatic obs_t rd_a();
    obs_t o;
    o.in_ready = int'(ifa.in_ready);   o.load_en = int'(ifa.load_en);
    o.issue_valid = int'(ifa.issue_valid); o.grp_idx = int'(ifa.grp_idx);
    o.col_base = int'(ifa.col_base);   o.lane_mask = int'(ifa.lane_mask);
    o.wr_en = int'(ifa.wr_en);         o.wr_idx = int'(ifa.wr_idx);
    o.out_valid = int'(ifa.out_valid); o.busy = int'(ifa.busy);
    return o;
  endfunction

  function automatic obs_t rd_b();
    obs_t o;
    o.in_ready = int'(ifb.in_ready);   o.load_en = int'(ifb.load_en);
    o.issue_valid = int'(ifb.issue_valid); o.grp_idx = int'(ifb.grp_idx);
    o.col_base = int'(ifb.col_base);   o.lane_mask = int'(ifb.lane_mask);
    o.wr_en = int'(ifb.wr_en);         o.wr_idx = int'(ifb.wr_idx);
    o.out_valid = int'(ifb.out_valid); o.busy = int'(ifb.busy);
    return o;
  endfunction

  // Reference: behaviour as a function of cycles elapsed since the accepted handshake.
  function automatic obs_t model_out(mstate_t m, int iv, int o_sz, int p, int ng, int pl);
    obs_t e;
    e = '0;
    if (m.active == 0) begin
      e.in_ready = 1;
      e.load_en  = iv;
    end else begin
      e.busy = 1;
      if (m.t >= 1 && m.t <= ng) begin
        e.issue_valid = 1;
        e.grp_idx     = m.t - 1;
        e.col_base    = (m.t - 1) * p;
        for (int k = 0; k < p; k++)
          if (((m.t - 1) * p + k) < o_sz) e.lane_mask = e.lane_mask | (1 << k);
      end
      if (m.t >= pl + 1 && m.t <= pl + ng) begin
        e.wr_en  = 1;
        e.wr_idx = m.t - pl - 1;
      end
      if (m.t >= ng + pl + 1) e.out_valid = 1;
    end
    return e;
  endfunction

  function automatic mstate_t model_step(mstate_t m, int rst, int iv, int orr, int ng, int pl);
    mstate_t n;
    n = m;
    if (rst != 0) begin
      n.active = 0; n.t = 0;
    end else if (m.active == 0) begin
      if (iv != 0) begin n.active = 1; n.t = 1; end
    end else if (m.t >= ng + pl + 1 && orr != 0) begin
      n.active = 0; n.t = 0;
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  function automatic vec_t mk(int iv, int orr, int inr, int ld, int iss, int g, int cb, int msk,
                              int wr, int wi, int ov, int bz);
    vec_t v;
    v.iv = iv; v.orr = orr;
    v.e = '{inr, ld, iss, g, cb, msk, wr, wi, ov, bz};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".in_ready"}, a.in_ready, e.in_ready);
    chk({tag, ".load_en"}, a.load_en, e.load_en);
    chk({tag, ".issue_valid"}, a.issue_valid, e.issue_valid);
    if (e.issue_valid != 0) begin
      chk({tag, ".grp_idx"}, a.grp_idx, e.grp_idx);
      chk({tag, ".col_base"}, a.col_base, e.col_base);
      chk({tag, ".lane_mask"}, a.lane_mask, e.lane_mask);
    end
    chk({tag, ".wr_en"}, a.wr_en, e.wr_en);
    if (e.wr_en != 0) chk({tag, ".wr_idx"}, a.wr_idx, e.wr_idx);
    chk({tag, ".out_valid"}, a.out_valid, e.out_valid);
    chk({tag, ".busy"}, a.busy, e.busy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 13; i++) begin
      step();
      ifa.in_valid  = tbl[i].iv[0];
      ifa.out_ready = tbl[i].orr[0];
      settle();
      cmp_obs($sformatf("%s[%0d]", tag, i), rd_a(), tbl[i].e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    obs_t    rst_e;
    mstate_t ma, mb;
    int      k, loads, last, ni, nw;
    int      iva, ora, ivb, orb, rr;

    // Default-configuration timeline, handshake at row 0.
    tbl[0]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 0, 0, 7, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 3, 3, 0, 0, 0, 1);
    for (int i = 3; i < 9; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    settle();
    rst_e = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    cmp_obs("reset_a", rd_a(), rst_e);
    cmp_obs("reset_b", rd_b(), rst_e);

    run_table("timeline");

    // Backpressure: out_valid must hold while out_ready stays low.
    step(); ifa.in_valid = 1'b1; ifa.out_ready = 1'b0; settle();
    chk("bp.load_en", int'(ifa.load_en), 1);
    k = 0;
    step(); ifa.in_valid = 1'b0; settle(); k++;
    while (ifa.out_valid !== 1'b1 && k < 40) begin step(); settle(); k++; end
    chk("bp.out_valid_cycle", k, A_NG + A_PL + 1);
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      chk("bp.hold_out_valid", int'(ifa.out_valid), 1);
      chk("bp.hold_in_ready", int'(ifa.in_ready), 0);
    end
    step(); ifa.out_ready = 1'b1; settle();
    chk("bp.release_out_valid", int'(ifa.out_valid), 1);
    step(); settle();
    chk("bp.idle_in_ready", int'(ifa.in_ready), 1);
    chk("bp.idle_out_valid", int'(ifa.out_valid), 0);
    chk("bp.idle_busy", int'(ifa.busy), 0);

    // in_valid held high across three vectors.
    loads = 0; last = -1;
    for (int c = 0; c < 40; c++) begin
      step(); ifa.in_valid = (c <= 24); ifa.out_ready = 1'b1; settle();
      if (ifa.load_en === 1'b1) begin
        if (last >= 0) chk("cont.spacing", c - last, A_NG + A_PL + 2);
        last = c;
        loads++;
      end
    end
    chk("cont.load_count", loads, 3);

    // Reset in the middle of DRAIN aborts the vector and its pending writes.
    for (int c = 0; c < 13; c++) begin
      step(); ifa.in_valid = (c == 0); reset = (c == 5); settle();
      if (c >= 1 && c <= 5) chk("rst.busy_before", int'(ifa.busy), 1);
      if (c >= 6) begin
        chk("rst.in_ready", int'(ifa.in_ready), 1);
        chk("rst.no_wr_en", int'(ifa.wr_en), 0);
        chk("rst.busy_after", int'(ifa.busy), 0);
      end
    end
    run_table("after_rst");

    // Single-group configuration.
    for (int c = 0; c < 11; c++) begin
      step(); ifb.in_valid = (c == 0); ifb.out_ready = 1'b1; settle();
      chk("small.issue_valid", int'(ifb.issue_valid), int'(c == 1));
      if (c == 1) begin
        chk("small.lane_mask", int'(ifb.lane_mask), 7);
        chk("small.col_base", int'(ifb.col_base), 0);
        chk("small.grp_idx", int'(ifb.grp_idx), 0);
      end
      chk("small.wr_en", int'(ifb.wr_en), int'(c == 7));
      if (c == 7) chk("small.wr_idx", int'(ifb.wr_idx), 0);
      chk("small.out_valid", int'(ifb.out_valid), int'(c == 8));
      chk("small.in_ready", int'(ifb.in_ready), int'(c == 0 || c >= 9));
    end

    // Random traffic against the reference model on both configurations.
    ma = '0; mb = '0; ni = 0; nw = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      iva = int'($urandom_range(0, 1)); ora = int'($urandom_range(0, 9) < 6);
      ivb = int'($urandom_range(0, 1)); orb = int'($urandom_range(0, 9) < 6);
      rr  = int'($urandom_range(0, 149) == 0);
      ifa.in_valid = iva[0]; ifa.out_ready = ora[0];
      ifb.in_valid = ivb[0]; ifb.out_ready = orb[0];
      reset = rr[0];
      settle();
      cmp_obs("rnd_a", rd_a(), model_out(ma, iva, A_OUT, A_PACK, A_NG, A_PL));
      cmp_obs("rnd_b", rd_b(), model_out(mb, ivb, B_OUT, B_PACK, B_NG, B_PL));
      ni += int'(ifa.issue_valid);
      nw += int'(ifa.wr_en);
      if (ifa.out_valid === 1'b1 && ora != 0) begin
        chk("vec.wr_vs_issue", nw, ni);
        chk("vec.issue_count", ni, A_NG);
        ni = 0; nw = 0;
      end
      if (rr != 0) begin ni = 0; nw = 0; end
      ma = model_step(ma, rr, iva, ora, A_NG, A_PL);
      mb = model_step(mb, rr, ivb, orb, B_NG, B_PL);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
